mem_bus_responder: RTL and testbench

//  Memory-side responder to the CPU control unit's stage enables. Turns fetch_en and mem_en into
//  req/ack transactions on an external memory bus, and drives needWait back so the control unit

---
 rtl/nqcpu_bus_pkg.sv | 27 ++
 rtl/mem_bus_responder_if.sv | 23 ++
 rtl/bus_timeout_timer.sv | 32 +++
 rtl/mem_bus_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_responder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nqcpu_bus_pkg.sv
// Shared definitions for the memory bus responder.
// Contents:
//   - one-hot FSM state codes IDLE/ACCESS/DONE and the matching state_e enum
//   - operation kind codes OP_FETCH/OP_LOAD/OP_STORE and the matching op_e enum
package nqcpu_bus_pkg;

  localparam logic [2:0] IDLE   = 3'b001;
  localparam logic [2:0] ACCESS = 3'b010;
  localparam logic [2:0] DONE   = 3'b100;

  localparam logic [1:0] OP_FETCH = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  typedef enum logic [2:0] {
    StIdle   = IDLE,
    StAccess = ACCESS,
    StDone   = DONE
  } state_e;

  typedef enum logic [1:0] {
    OpFetch = OP_FETCH,
    OpLoad  = OP_LOAD,
    OpStore = OP_STORE
  } op_e;

endpackage

// File: rtl/mem_bus_responder_if.sv
// External memory bus: single outstanding req/ack transaction.
// Signals:
//   req    request, held until ack
//   we     write strobe, valid with req
//   addr   address, stable while req=1
//   wdata  write data, stable while req=1
//   ack    completion; rdata valid in the same cycle
//   rdata  read data
// Modports: master (responder side, drives req), slave (memory side, drives ack).
interface mem_bus_responder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/bus_timeout_timer.sv
// Access timeout down-counter.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   load      reload with TIMEOUT_CYCLES (start of an access)
//   dec       one ACCESS cycle passed without ack
//   expired   this decrement is the last one; the access must be aborted now
module bus_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expired
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(TIMEOUT_CYCLES);
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Expiring on the 1->0 step gives exactly TIMEOUT_CYCLES ACCESS cycles.
  assign expired = dec && (cnt_q <= CNT_W'(1));
endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU control unit.
// Converts fetch_en / mem_en stage enables into req/ack transactions on the external bus and
// stalls the control unit through needWait until the data has been captured.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fetch_en, mem_en  stage requests (fetch has priority when both are high)
//   mem_we            1 = store, 0 = load
//   pc, mem_addr      fetch / data address
//   mem_wdata         store data
//   needWait          combinational stall to the control unit
//   instr_out         last fetched instruction
//   mem_rdata         last load data
//   ext               external bus (master modport)
//   bus_error         sticky timeout flag (BUS_TIMEOUT_EN only)
//   dbg_state         one-hot state {DONE, ACCESS, IDLE}
// Build option: define BUS_TIMEOUT_EN to abort accesses that see no ack for TIMEOUT_CYCLES.
module mem_bus_responder
  import nqcpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
`ifdef BUS_TIMEOUT_EN
  ,
  // Only meaningful with the timeout option; absent otherwise.
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              needWait,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] mem_rdata,
  mem_bus_responder_if.master ext,
`ifdef BUS_TIMEOUT_EN
  output logic              bus_error,
`endif
  output logic [2:0]        dbg_state
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] instr_q, rdata_q;

  logic              start;        // IDLE -> ACCESS this cycle
  logic              complete;     // ACCESS -> DONE by ack or timeout
  logic              timed_out;    // ACCESS -> DONE by timeout
  logic [DATA_W-1:0] capture;
  logic              timer_expired;

`ifdef BUS_TIMEOUT_EN
  logic error_q;

  bus_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (start),
    .dec    ((state_q == StAccess) && !ext.ack),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (timed_out) begin
      error_q <= 1'b1;
    end
  end

  assign bus_error = error_q;
`else
  assign timer_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    complete  = 1'b0;
    timed_out = 1'b0;
    needWait  = 1'b0;
    op_d      = fetch_en ? OpFetch : (mem_we ? OpStore : OpLoad);
    unique case (state_q)
      StIdle: begin
        if (fetch_en || mem_en) begin
          state_d  = StAccess;
          start    = 1'b1;
          needWait = 1'b1;
        end
      end
      StAccess: begin
        needWait = 1'b1;
        // An ack in the expiry cycle takes precedence over the timeout.
        if (ext.ack) begin
          state_d  = StDone;
          complete = 1'b1;
        end else if (timer_expired) begin
          state_d   = StDone;
          complete  = 1'b1;
          timed_out = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign capture = timed_out ? '0 : ext.rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpFetch;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        op_q    <= op_d;
        req_q   <= 1'b1;
        we_q    <= !fetch_en && mem_we;
        addr_q  <= fetch_en ? pc : mem_addr;
        wdata_q <= mem_wdata;
      end
      if (complete) begin
        req_q <= 1'b0;
        if (op_q == OpFetch) begin
          instr_q <= capture;
        end else if (op_q == OpLoad) begin
          rdata_q <= capture;
        end
      end
    end
  end

  assign ext.req   = req_q;
  assign ext.we    = we_q;
  assign ext.addr  = addr_q;
  assign ext.wdata = wdata_q;
  assign instr_out = instr_q;
  assign mem_rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: reset state, directed vector table, spurious ack,
// randomized transactions against a transaction-level model, reset mid-access and (with
// BUS_TIMEOUT_EN) the access timeout.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en, mem_en, mem_we;
  logic [15:0] pc, mem_addr, mem_wdata;
  logic        needWait;
  logic [15:0] instr_out, mem_rdata;
  logic [2:0]  dbg_state;
`ifdef BUS_TIMEOUT_EN
  logic        bus_error;
`endif

  always #5 clk = ~clk;

  mem_bus_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_bus_responder #(
    .ADDR_W(16),
    .DATA_W(16)
`ifdef BUS_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_en (fetch_en),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .pc       (pc),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .needWait (needWait),
    .instr_out(instr_out),
    .mem_rdata(mem_rdata),
    .ext      (bus),
`ifdef BUS_TIMEOUT_EN
    .bus_error(bus_error),
`endif
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one stage: raises the enables, acks in ACCESS cycle number `delay` (0-based),
  // counts needWait-high cycles, and drops the enables after the DONE cycle.
  task automatic run_txn(input bit f, input bit m, input bit we, input logic [15:0] a_pc,
                         input logic [15:0] a_addr, input logic [15:0] wd,
                         input logic [15:0] rd, input int delay, output int waits,
                         output logic [15:0] s_addr, output logic [15:0] s_wdata,
                         output logic s_we, output bit stable);
    int  acc   = 0;
    int  cyc   = 0;
    bit  first = 1'b1;
    bit  done  = 1'b0;
    waits   = 0;
    stable  = 1'b1;
    s_addr  = '0;
    s_wdata = '0;
    s_we    = 1'b0;
    @(negedge clk);
    fetch_en  = f;
    mem_en    = m;
    mem_we    = we;
    pc        = a_pc;
    mem_addr  = a_addr;
    mem_wdata = wd;
    while (!done) begin
      bus.ack   = bus.req && (acc == delay);
      bus.rdata = bus.ack ? rd : ~rd;
      #1;
      if (needWait) waits++;
      else done = 1'b1;
      if (bus.req) begin
        if (first) begin
          s_addr  = bus.addr;
          s_wdata = bus.wdata;
          s_we    = bus.we;
          first   = 1'b0;
        end else if (bus.addr !== s_addr || bus.wdata !== s_wdata || bus.we !== s_we) begin
          stable = 1'b0;
        end
        acc++;
      end
      cyc++;
      if (cyc > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL txn_bound: needWait still 1 after %0d cycles, expected release", cyc);
        done = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    @(negedge clk);
    fetch_en = 1'b0;
    mem_en   = 1'b0;
    bus.ack  = 1'b0;
  endtask

  typedef struct {
    bit          f, m, we;
    logic [15:0] pc, addr, wdata, rdata;
    int          delay;
    int          exp_wait;
    logic [15:0] exp_addr;
    logic        exp_we;
    logic [15:0] exp_instr, exp_rdata;
  } vec_t;

  vec_t        vecs[4];
  int          waits;
  logic [15:0] s_addr, s_wdata;
  logic        s_we;
  bit          stable;
  logic [15:0] m_instr, m_rdata;

  initial begin
    rst       = 1'b1;
    fetch_en  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    pc        = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    bus.ack   = 1'b0;
    bus.rdata = '0;

    //        f  m  we  pc       addr     wdata    rdata    dly wait addr    we instr    rdata
    vecs[0] = '{1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'hA5C3, 0, 2, 16'h0010, 0,
                16'hA5C3, 16'h0000};
    vecs[1] = '{0, 1, 0, 16'h0000, 16'h0200, 16'h0000, 16'h1234, 3, 5, 16'h0200, 0,
                16'hA5C3, 16'h1234};
    vecs[2] = '{0, 1, 1, 16'h0000, 16'h0300, 16'hBEEF, 16'hDEAD, 2, 4, 16'h0300, 1,
                16'hA5C3, 16'h1234};
    vecs[3] = '{1, 1, 1, 16'h0020, 16'h0400, 16'h1111, 16'h5A5A, 1, 3, 16'h0020, 0,
                16'h5A5A, 16'h1234};

    #12;
    check("rst_instr", instr_out, 16'h0);
    check("rst_rdata", mem_rdata, 16'h0);
    check("rst_req", bus.req, 1'b0);
    check("rst_we", bus.we, 1'b0);
    check("rst_addr", bus.addr, 16'h0);
    check("rst_wdata", bus.wdata, 16'h0);
    check("rst_state", dbg_state, 3'b001);
    check("rst_needwait", needWait, 1'b0);
`ifdef BUS_TIMEOUT_EN
    check("rst_bus_error", bus_error, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i].f, vecs[i].m, vecs[i].we, vecs[i].pc, vecs[i].addr, vecs[i].wdata,
              vecs[i].rdata, vecs[i].delay, waits, s_addr, s_wdata, s_we, stable);
      check($sformatf("vec%0d_wait", i), waits, vecs[i].exp_wait);
      check($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_we", i), s_we, vecs[i].exp_we);
      check($sformatf("vec%0d_stable", i), stable, 1'b1);
      check($sformatf("vec%0d_instr", i), instr_out, vecs[i].exp_instr);
      check($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
      if (vecs[i].we && !vecs[i].f) check($sformatf("vec%0d_wdata", i), s_wdata, vecs[i].wdata);
      check($sformatf("vec%0d_idle", i), dbg_state, 3'b001);
    end

    // Spurious ack while idle must be ignored.
    @(negedge clk);
    bus.ack   = 1'b1;
    bus.rdata = 16'hFFFF;
    @(negedge clk);
    check("spur_state", dbg_state, 3'b001);
    check("spur_req", bus.req, 1'b0);
    check("spur_instr", instr_out, 16'h5A5A);
    check("spur_rdata", mem_rdata, 16'h1234);
    bus.ack = 1'b0;

    // Randomized transactions against a transaction-level model.
    m_instr = instr_out === 16'h5A5A ? 16'h5A5A : 16'h5A5A;
    m_rdata = 16'h1234;
    for (int i = 0; i < 40; i++) begin
      int          kind;
      int          dly;
      bit          f, m, we;
      logic [15:0] r_pc, r_addr, r_wd, r_rd;
      kind   = int'($urandom_range(0, 3));
      dly    = int'($urandom_range(0, 4));
      f      = (kind == 0) || (kind == 3);
      m      = (kind != 0);
      we     = (kind == 2) || ((kind == 3) && $urandom_range(0, 1) == 1);
      r_pc   = 16'($urandom);
      r_addr = 16'($urandom);
      r_wd   = 16'($urandom);
      r_rd   = 16'($urandom);
      run_txn(f, m, we, r_pc, r_addr, r_wd, r_rd, dly, waits, s_addr, s_wdata, s_we, stable);
      if (f) m_instr = r_rd;
      else if (!we) m_rdata = r_rd;
      check($sformatf("rnd%0d_wait", i), waits, dly + 2);
      check($sformatf("rnd%0d_addr", i), s_addr, f ? r_pc : r_addr);
      check($sformatf("rnd%0d_we", i), s_we, !f && we);
      check($sformatf("rnd%0d_stable", i), stable, 1'b1);
      check($sformatf("rnd%0d_instr", i), instr_out, m_instr);
      check($sformatf("rnd%0d_rdata", i), mem_rdata, m_rdata);
      if (!f && we) check($sformatf("rnd%0d_wdata", i), s_wdata, r_wd);
    end

    // Reset in the middle of an access.
    @(negedge clk);
    fetch_en = 1'b1;
    pc       = 16'h0044;
    bus.ack  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_pre_state", dbg_state, 3'b010);
    check("midrst_pre_req", bus.req, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_req", bus.req, 1'b0);
    check("midrst_state", dbg_state, 3'b001);
    check("midrst_instr", instr_out, 16'h0);
    check("midrst_rdata", mem_rdata, 16'h0);
    @(negedge clk);
    rst      = 1'b0;
    fetch_en = 1'b0;
    run_txn(1, 0, 0, 16'h0050, 16'h0, 16'h0, 16'h7777, 1, waits, s_addr, s_wdata, s_we, stable);
    check("postrst_wait", waits, 3);
    check("postrst_addr", s_addr, 16'h0050);
    check("postrst_instr", instr_out, 16'h7777);

`ifdef BUS_TIMEOUT_EN
    check("pre_to_error", bus_error, 1'b0);
    // No ack: 8 ACCESS cycles plus the IDLE request cycle.
    run_txn(1, 0, 0, 16'h0060, 16'h0, 16'h0, 16'h9999, 1000, waits, s_addr, s_wdata, s_we,
            stable);
    check("to_wait", waits, 9);
    check("to_error", bus_error, 1'b1);
    check("to_instr", instr_out, 16'h0);
    // Error is sticky across a normal access.
    run_txn(0, 1, 0, 16'h0, 16'h0070, 16'h0, 16'h4242, 0, waits, s_addr, s_wdata, s_we, stable);
    check("to_sticky", bus_error, 1'b1);
    check("to_after_rdata", mem_rdata, 16'h4242);
    // Ack in the last permitted cycle completes normally.
    run_txn(0, 1, 0, 16'h0, 16'h0080, 16'h0, 16'h3131, 7, waits, s_addr, s_wdata, s_we, stable);
    check("to_edge_wait", waits, 9);
    check("to_edge_rdata", mem_rdata, 16'h3131);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
